mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit between the core's execute stage and data port 2 of the main memory (addr2/d22/we2/wstrb/q2). It accepts one RV32I load or store at a time and generates byte strobes and lane-replicated write data. Load data returns from the memory's registered read port and is extracted and sign- or zero-extended. Misaligned, out-of-range and illegal-width accesses are rejected before any memory side effect.

## Interface
Parameters:
- RAM_SIZE, 4, memory size in KiB; legal byte addresses are 0 .. RAM_SIZE*1024-1
- ADDR_WIDTH, 32, request address width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; request taken on a cycle with req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I width/sign code
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_err  out  2  0 OK, 1 misaligned, 2 access fault, 3 illegal funct3
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- mem_addr  out  32  to memory addr2
- mem_wdata  out  32  to memory d22
- mem_we  out  1  to memory we2
- mem_wstrb  out  4  to memory wstrb
- mem_rdata  in  32  from memory q2; valid the cycle after the address edge

## Operation
- FSM states: IDLE, LOAD, RESP. Reset state IDLE.
- IDLE: req_ready=1. On acceptance:
  - error-free load → LOAD
  - error-free store → RESP
  - any error → RESP with rsp_err latched
- LOAD: capture extended data into rsp_rdata, then → RESP.
- RESP: rsp_valid=1, req_ready=0. Next state IDLE.
- Error check priority: illegal funct3 > misaligned > access fault.
  - Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal stores: 000 SB, 001 SH, 010 SW.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Access fault: addr ≥ RAM_SIZE*1024.
- mem_addr = {req_addr[31:2],2'b00}, driven combinationally from the request.
- mem_we = req_valid & state==IDLE & req_we & no error & ~reset.
- Strobes:
  - SB: 0001<<addr[1:0]
  - SH: 0011<<addr[1:0]
  - SW: 1111
  - 0000 when mem_we=0
- Write data:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Loads:
  - funct3 and addr[1:0] are registered at acceptance.
  - In LOAD, the selected byte/halfword is taken from mem_rdata >> 8*offset.
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
- Outputs are unaffected by req_* outside acceptance cycles. Requests presented while not in IDLE are held off by req_ready=0.

## Timing
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_err 0, rsp_rdata 0, mem_we 0, mem_wstrb 0.
- Store: accepted at edge E0, and the memory writes at E0. rsp_valid is high in the cycle after E0. Next acceptance is possible 2 cycles after the previous one.
- Load: address is captured by the memory at E0, and mem_rdata is valid during LOAD. rsp_valid/rsp_rdata are high in the second cycle after E0. Next acceptance is possible 3 cycles after the previous one.
- Error: no memory write. rsp_valid is high in the cycle after acceptance.
- Reset asserted mid-operation: immediately return to IDLE and clear the outputs. The in-flight load is dropped with no response. A store whose acceptance edge coincides with reset assertion must not write, since mem_we is gated by reset.
- The acceptance edge and the write are the same edge, so the memory's read-before-write on port 2 is never relied upon.

## Structure
- Package mem_lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - rsp_err enum (ERR_NONE, ERR_MISALIGN, ERR_FAULT, ERR_ILLEGAL)
  - FSM state enum
- One combinational sub-module, lsu_load_align, takes (mem_rdata, offset, funct3) and produces the extended data. It is instantiated once.

## Test plan
Preload the word at 0x10 = 0x8077_F0A5 (RAM_SIZE=4).
- LB 0x11 → rsp_rdata 0xFFFF_FFF0, rsp_err 0, rsp_valid 2 cycles after acceptance.
- LBU 0x13 → 0x0000_0080. LHU 0x12 → 0x0000_8077. LH 0x12 → 0xFFFF_8077. LW 0x10 → 0x8077_F0A5.
- SB 0x12 with wdata 0x1234_56CC → mem_wstrb 0100, mem_wdata 0xCCCC_CCCC, mem_we for one cycle. A subsequent LW 0x10 returns 0x80CC_F0A5.
- LW 0x12 → rsp_err 1 and mem_we 0. SH 0x1000 → rsp_err 2, no write. Load funct3 011 → rsp_err 3. Each error returns rsp_rdata 0.
- Reset asserted during LOAD → rsp_valid never pulses for that load, and req_ready=1 immediately. Reset on the SW acceptance edge → target word unchanged.
- Back-to-back req_valid held high → req_ready low in LOAD/RESP. The second request is accepted exactly 3 cycles after a load and 2 cycles after a store.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the load/store unit on memory data port 2.
package mem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_FAULT    = 2'd2,
        ERR_ILLEGAL  = 2'd3
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_load_align.sv
// Extracts the addressed byte/halfword from a memory word and sign- or zero-extends it.
module lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] ext_data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rdata >> {offset, 3'b000};
        case (funct3)
            F3_B:    ext_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    ext_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   ext_data = {24'b0, shifted[7:0]};
            F3_HU:   ext_data = {16'b0, shifted[15:0]};
            default: ext_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// RV32I load/store unit: one access at a time, byte strobes, lane-replicated store data,
// extended load data from the registered read port, and early rejection of bad accesses.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata
);

    localparam logic [ADDR_WIDTH:0] RAM_BYTES = (ADDR_WIDTH+1)'(RAM_SIZE * 1024);

    lsu_state_e  state_q, state_d;
    lsu_err_e    err_q, err_d, req_err;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  ld_f3_q, ld_f3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [31:0] ext_data;
    logic [3:0]  strb;
    logic        legal;
    logic        accept;

    // Illegal funct3 outranks misalignment, which outranks an out-of-range address.
    always_comb begin
        req_err = ERR_NONE;
        if (req_we) begin
            legal = req_funct3 inside {F3_B, F3_H, F3_W};
        end else begin
            legal = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
        if (!legal) begin
            req_err = ERR_ILLEGAL;
        end else if (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))) begin
            req_err = ERR_MISALIGN;
        end else if ({1'b0, req_addr} >= RAM_BYTES) begin
            req_err = ERR_FAULT;
        end
    end

    always_comb begin
        case (req_funct3[1:0])
            2'b00: begin
                strb      = 4'b0001 << req_addr[1:0];
                mem_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                strb      = 4'b0011 << req_addr[1:0];
                mem_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                strb      = 4'b1111;
                mem_wdata = req_wdata;
            end
        endcase
    end

    assign accept    = req_valid && (state_q == IDLE);
    // Gating by reset keeps a store colliding with reset assertion from reaching memory.
    assign mem_we    = accept && req_we && (req_err == ERR_NONE) && !reset;
    assign mem_wstrb = mem_we ? strb : 4'b0000;
    assign mem_addr  = 32'(req_addr) & 32'hFFFF_FFFC;
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;

    lsu_load_align u_align (
        .mem_rdata (mem_rdata),
        .offset    (ld_off_q),
        .funct3    (ld_f3_q),
        .ext_data  (ext_data)
    );

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        ld_f3_d  = ld_f3_q;
        ld_off_d = ld_off_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d    = req_err;
                    rdata_d  = '0;
                    ld_f3_d  = req_funct3;
                    ld_off_d = req_addr[1:0];
                    state_d  = (req_err == ERR_NONE && !req_we) ? LOAD : RESP;
                end
            end
            LOAD: begin
                rdata_d = ext_data;
                state_d = RESP;
            end
            RESP: begin
                err_d   = ERR_NONE;
                rdata_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            err_q    <= ERR_NONE;
            rdata_q  <= '0;
            ld_f3_q  <= '0;
            ld_off_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu with a byte-array reference model and a port-2 memory model.
module tb_mem_lsu;

    localparam int unsigned RAM_SIZE  = 4;
    localparam int unsigned RAM_BYTES = RAM_SIZE * 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid;
    logic [1:0]  rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    logic [3:0]  mem_wstrb;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] ram [RAM_BYTES/4];
    logic [7:0]  ref_mem [RAM_BYTES];

    int          obs_lat;
    logic        obs_timeout, obs_tail, obs_we;
    logic [1:0]  obs_err;
    logic [31:0] obs_rdata, obs_wdata, obs_addr;
    logic [3:0]  obs_strb;

    mem_lsu #(.RAM_SIZE(RAM_SIZE), .ADDR_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Port-2 memory: byte-strobed write, registered read.
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= ram[mem_addr[11:2]];
    end

    function automatic logic [1:0] exp_err(input logic we, input logic [2:0] f3,
                                           input logic [31:0] a);
        int unsigned sz;
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 <= 3'd5);
        if (!legal) return 2'd3;
        sz = 32'd1 << f3[1:0];
        if (a % sz != 0) return 2'd1;
        if (a >= RAM_BYTES) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a);
        int sz;
        longint v;
        sz = 1 << f3[1:0];
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (longint'(ref_mem[a[11:0] + 12'(i)]) << (8*i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8*sz));
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s;
        longint w, lo, hi;
        lo = longint'(a);
        hi = lo + (longint'(1) << f3[1:0]);
        for (int i = 0; i < 4; i++) begin
            w = longint'({a[31:2], 2'b00}) + i;
            s[i] = (w >= lo) && (w < hi);
        end
        return s;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int sz;
        sz = 1 << f3[1:0];
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
        return r;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < (1 << f3[1:0]); i++) ref_mem[a[11:0] + 12'(i)] = wd[8*i +: 8];
    endtask

    // Drives one request, then records what the unit did at acceptance and at response.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        int n;
        obs_timeout = 1'b0;
        obs_lat = 0;
        obs_err = '0;
        obs_rdata = '0;
        obs_tail = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = a;
        req_wdata = wd;
        #1;
        n = 0;
        while (!req_ready && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            obs_timeout = 1'b1;
            req_valid = 1'b0;
            return;
        end
        obs_we = mem_we;
        obs_strb = mem_wstrb;
        obs_wdata = mem_wdata;
        obs_addr = mem_addr;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                obs_lat = k;
                obs_err = rsp_err;
                obs_rdata = rsp_rdata;
                break;
            end
        end
        if (obs_lat == 0) begin
            obs_timeout = 1'b1;
            return;
        end
        @(negedge clk);
        obs_tail = rsp_valid;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h20;
        req_wdata = 32'h1111_2222;
        repeat (2) @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_err !== 2'd0) begin n_fail++;
            $display("FAIL reset_rsp_err: got %0d want 0", rsp_err); end
        n_cmp++; if (rsp_rdata !== 32'd0) begin n_fail++;
            $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++;
            $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_cmp++; if (mem_wstrb !== 4'b0000) begin n_fail++;
            $display("FAIL reset_mem_wstrb: got %b want 0000", mem_wstrb); end
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Checks one completed transaction against the reference model.
    task automatic test_txn(input string name, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
        logic [1:0]  e_err;
        logic [31:0] e_rd, e_wd;
        logic        e_we;
        logic [3:0]  e_strb;
        int          e_lat;
        e_err = exp_err(we, f3, a);
        e_we = we && (e_err == 2'd0);
        e_rd = (!we && e_err == 2'd0) ? exp_load(f3, a) : 32'd0;
        e_lat = (!we && e_err == 2'd0) ? 2 : 1;
        e_strb = e_we ? exp_strb(f3, a) : 4'b0000;
        e_wd = exp_wdata(f3, wd);
        do_req(we, f3, a, wd);
        n_cmp++;
        if (obs_timeout) begin n_fail++;
            $display("FAIL %s_timeout: no acceptance/response for a=%h f3=%0d", name, a, f3);
            return;
        end
        if (e_we) ref_store(f3, a, wd);
        n_cmp++; if (obs_err !== e_err) begin n_fail++;
            $display("FAIL %s_err a=%h f3=%0d we=%b: got %0d want %0d", name, a, f3, we,
                     obs_err, e_err); end
        n_cmp++; if (obs_rdata !== e_rd) begin n_fail++;
            $display("FAIL %s_rdata a=%h f3=%0d: got %h want %h", name, a, f3, obs_rdata,
                     e_rd); end
        n_cmp++; if (obs_lat != e_lat) begin n_fail++;
            $display("FAIL %s_latency a=%h: got %0d want %0d", name, a, obs_lat, e_lat); end
        n_cmp++; if (obs_tail !== 1'b0) begin n_fail++;
            $display("FAIL %s_pulse a=%h: rsp_valid got %b want 0 after response", name, a,
                     obs_tail); end
        n_cmp++; if (obs_we !== e_we || obs_strb !== e_strb) begin n_fail++;
            $display("FAIL %s_write a=%h f3=%0d: got we=%b strb=%b want we=%b strb=%b", name, a,
                     f3, obs_we, obs_strb, e_we, e_strb); end
        n_cmp++; if (obs_addr !== {a[31:2], 2'b00}) begin n_fail++;
            $display("FAIL %s_addr: got %h want %h", name, obs_addr, {a[31:2], 2'b00}); end
        if (e_we) begin
            n_cmp++; if (obs_wdata !== e_wd) begin n_fail++;
                $display("FAIL %s_wdata a=%h: got %h want %h", name, a, obs_wdata, e_wd); end
        end
    endtask

    task automatic test_loads;
        test_txn("lb", 1'b0, 3'b000, 32'h11, 32'h0);
        n_cmp++; if (obs_rdata !== 32'hFFFF_FFF0) begin n_fail++;
            $display("FAIL lb_const: got %h want fffffff0", obs_rdata); end
        test_txn("lbu", 1'b0, 3'b100, 32'h13, 32'h0);
        test_txn("lhu", 1'b0, 3'b101, 32'h12, 32'h0);
        test_txn("lh", 1'b0, 3'b001, 32'h12, 32'h0);
        test_txn("lw", 1'b0, 3'b010, 32'h10, 32'h0);
    endtask

    task automatic test_store;
        test_txn("sb", 1'b1, 3'b000, 32'h12, 32'h1234_56CC);
        n_cmp++; if (obs_strb !== 4'b0100 || obs_wdata !== 32'hCCCC_CCCC) begin n_fail++;
            $display("FAIL sb_const: got strb=%b wdata=%h want 0100 cccccccc", obs_strb,
                     obs_wdata); end
        test_txn("lw_after_sb", 1'b0, 3'b010, 32'h10, 32'h0);
        n_cmp++; if (obs_rdata !== 32'h80CC_F0A5) begin n_fail++;
            $display("FAIL lw_after_sb_const: got %h want 80ccf0a5", obs_rdata); end
        test_txn("sh", 1'b1, 3'b001, 32'h16, 32'hABCD_5A3C);
        test_txn("sw", 1'b1, 3'b010, 32'h18, 32'h0BAD_F00D);
        test_txn("lw_after_sw", 1'b0, 3'b010, 32'h18, 32'h0);
    endtask

    task automatic test_errors;
        test_txn("lw_misalign", 1'b0, 3'b010, 32'h12, 32'h0);
        test_txn("sh_fault", 1'b1, 3'b001, 32'h1000, 32'hFFFF_FFFF);
        test_txn("ld_illegal", 1'b0, 3'b011, 32'h10, 32'h0);
        test_txn("sw_illegal", 1'b1, 3'b100, 32'h10, 32'h0);
        test_txn("lh_misalign_fault", 1'b0, 3'b001, 32'h1001, 32'h0);
        test_txn("lw_after_errors", 1'b0, 3'b010, 32'h10, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        int mode;
        for (int i = 0; i < 80; i++) begin
            mode = int'($urandom_range(0, 9));
            if (mode == 0) a = 32'd4088 + $urandom_range(0, 15);
            else if (mode == 1) a = $urandom;
            else a = $urandom_range(0, 31);
            test_txn("rand", 1'($urandom), 3'($urandom), a, $urandom);
        end
    endtask

    task automatic test_reset_during_load;
        logic seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b0;
        req_funct3 = 3'b010;
        req_addr = 32'h10;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_load_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin n_fail++;
            $display("FAIL rst_load_outputs: got valid=%b rdata=%h want 0 0", rsp_valid,
                     rsp_rdata); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++;
            $display("FAIL rst_load_no_rsp: got rsp_valid pulse=%b want 0", seen); end
    endtask

    task automatic test_reset_on_store;
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = 32'h10;
        req_wdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (mem_we !== 1'b1) begin n_fail++;
            $display("FAIL rst_sw_pre_we: got %b want 1", mem_we); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_fail++;
            $display("FAIL rst_sw_we_gated: got %b want 0", mem_we); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        test_txn("lw_after_rst_sw", 1'b0, 3'b010, 32'h10, 32'h0);
    endtask

    task automatic test_back_to_back;
        int gap;
        int lat;
        logic first_we;
        logic [31:0] e_rd;
        for (int t = 0; t < 2; t++) begin
            first_we = (t == 1);
            @(negedge clk);
            req_valid = 1'b1;
            req_we = first_we;
            req_funct3 = 3'b010;
            req_addr = 32'h20;
            req_wdata = $urandom;
            @(posedge clk);
            #1;
            if (first_we) ref_store(3'b010, 32'h20, req_wdata);
            req_we = 1'b0;
            gap = 0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                #1;
                if (req_ready) begin
                    gap = k;
                    break;
                end
            end
            n_cmp++; if (gap != (first_we ? 2 : 3)) begin n_fail++;
                $display("FAIL b2b_gap first_we=%b: got %0d want %0d", first_we, gap,
                         first_we ? 2 : 3); end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            e_rd = exp_load(3'b010, 32'h20);
            lat = 0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    lat = k;
                    break;
                end
            end
            n_cmp++; if (lat != 2 || rsp_rdata !== e_rd) begin n_fail++;
                $display("FAIL b2b_second_rsp first_we=%b: got lat=%0d rdata=%h want 2 %h",
                         first_we, lat, rsp_rdata, e_rd); end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < RAM_BYTES/4; i++) begin
            w = (i == 4) ? 32'h8077_F0A5 : $urandom;
            ram[i] <= w;
            for (int b = 0; b < 4; b++) ref_mem[i*4 + b] = w[8*b +: 8];
        end
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        test_reset();
        test_loads();
        test_store();
        test_errors();
        test_reset_during_load();
        test_reset_on_store();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
